// File: rtl/mem_ss_csr_pkg.sv
// Shared types, register offsets and default identity values for the MEM_SS CSR block.
package mem_ss_csr_pkg;

    typedef struct packed {
        logic [3:0]  feat_type;
        logic [7:0]  rsvd1;
        logic [3:0]  min_ver;
        logic [6:0]  rsvd0;
        logic        eol;
        logic [23:0] nxt_dfh_offset;
        logic [3:0]  maj_ver;
        logic [11:0] feat_id;
    } t_dfh;

    typedef enum logic [1:0] {
        EFF_IDLE   = 2'd0,
        EFF_RUN    = 2'd1,
        EFF_FROZEN = 2'd2
    } t_effmon_state;

    localparam logic [15:0] ADDR_DFH        = 16'h0000;
    localparam logic [15:0] ADDR_EMIF_STAT  = 16'h0008;
    localparam logic [15:0] ADDR_EMIF_CAP   = 16'h0010;
    localparam logic [15:0] ADDR_MEMSS_VER  = 16'h0860;
    localparam logic [15:0] ADDR_FEAT_LIST2 = 16'h0868;
    localparam logic [15:0] ADDR_IF_ATTR    = 16'h0870;
    localparam logic [15:0] ADDR_SCRATCH    = 16'h0880;
    localparam logic [15:0] ADDR_ERR_STAT   = 16'h08B0;
    localparam logic [15:0] ADDR_CH_ATTR0   = 16'h0900;
    localparam logic [15:0] ADDR_EFF_CTRL   = 16'h1000;
    localparam logic [15:0] ADDR_EFF_TOTAL  = 16'h1008;
    localparam logic [15:0] ADDR_EFF_BUSY0  = 16'h1010;

    localparam logic [3:0]  DFH_FEAT_TYPE   = 4'h3;
    localparam logic [11:0] DEF_FEAT_ID     = 12'h9;
    localparam logic [23:0] DEF_NXT_DFH     = 24'h0;
    localparam logic        DEF_EOL         = 1'b1;
    localparam logic [15:0] DEF_MAJ_VER     = 16'h1;
    localparam logic [7:0]  DEF_MIN_VER     = 8'h0;
    localparam logic [7:0]  DEF_MEM_TYPE    = 8'h1;
    localparam logic [1:0]  DEF_IF_TYPE     = 2'h0;
    localparam logic [3:0]  DEF_RDY_LAT     = 4'h3;

    // auto-precharge, one user pool, one write copy
    localparam logic [63:0] CH_ATTR_FIXED   = 64'h0000_0000_0910_0000;

    function automatic logic [12:0] word_addr(input logic [15:0] byte_addr);
        return byte_addr[15:3];
    endfunction

endpackage

// File: rtl/mem_ss_csr_regs_if.sv
// Host CSR access bus: single-cycle strobes, registered one-cycle read return.
interface mem_ss_csr_regs_if;
    logic        csr_wr;
    logic        csr_rd;
    logic [15:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [7:0]  csr_wstrb;
    logic [63:0] csr_rdata;
    logic        csr_rvalid;

    modport master (
        output csr_wr, csr_rd, csr_addr, csr_wdata, csr_wstrb,
        input  csr_rdata, csr_rvalid
    );

    modport slave (
        input  csr_wr, csr_rd, csr_addr, csr_wdata, csr_wstrb,
        output csr_rdata, csr_rvalid
    );
endinterface

// File: rtl/mem_ss_effmon.sv
// Efficiency monitor: IDLE/RUN/FROZEN control plus one total-cycle counter and
// one beat counter per channel, all saturating, with a sticky overflow flag.
module mem_ss_effmon
    import mem_ss_csr_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         clear_i,
    input  logic [NUM_CH-1:0]            beat_i,
    output t_effmon_state                state_o,
    output logic                         overflow_o,
    output logic [NUM_CH:0][CNT_W-1:0]   cnt_o
);

    t_effmon_state state_q, state_d;
    logic          overflow_q, overflow_d;
    logic [NUM_CH:0] inc;
    logic [NUM_CH:0] sat_hit;

    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_PRE_SAT  = {{(CNT_W-1){1'b1}}, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EFF_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    // stop dominates start; start from RUN is a no-op
    always_comb begin
        state_d = state_q;
        case (state_q)
            EFF_IDLE, EFF_FROZEN: if (start_i && !stop_i) state_d = EFF_RUN;
            EFF_RUN:              if (stop_i)             state_d = EFF_FROZEN;
            default:              state_d = EFF_IDLE;
        endcase
    end

    // lane 0 counts every RUN cycle, lane c+1 counts channel c beats
    assign inc = {beat_i, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi <= NUM_CH; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             bump;

            assign bump        = !clear_i && (state_q == EFF_RUN) && inc[gi] && (cnt_q != '1);
            assign sat_hit[gi] = bump && (cnt_q == CNT_PRE_SAT);

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i)   cnt_d = '0;
                else if (bump) cnt_d = cnt_q + CNT_ONE;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign cnt_o[gi] = cnt_q;
        end
    endgenerate

    always_comb begin
        overflow_d = overflow_q | (|sat_hit);
        if (clear_i) overflow_d = 1'b0;
    end

    assign state_o    = state_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/mem_ss_csr_regs.sv
// MEM_SS CSR block: identity/status registers, scratch, sticky channel errors and
// the efficiency monitor, behind a one-cycle registered read port.
module mem_ss_csr_regs
    import mem_ss_csr_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          HPS_PRESENT    = 0,
    parameter int          CNT_W          = 32,
    parameter logic [11:0] FEAT_ID        = DEF_FEAT_ID,
    parameter logic [23:0] NXT_DFH_OFFSET = DEF_NXT_DFH,
    parameter logic        EOL            = DEF_EOL,
    parameter logic [15:0] MAJ_VER        = DEF_MAJ_VER,
    parameter logic [7:0]  MIN_VER        = DEF_MIN_VER,
    parameter logic [7:0]  MEM_TYPE       = DEF_MEM_TYPE,
    parameter logic [1:0]  IF_TYPE        = DEF_IF_TYPE,
    parameter logic [3:0]  RDY_LATENCY    = DEF_RDY_LAT
) (
    input  logic              clk,
    input  logic              rst,
    mem_ss_csr_regs_if.slave  csr,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    input  logic [NUM_CH-1:0] ch_beat,
    input  logic [NUM_CH-1:0] ch_err,
    output logic              effmon_running
);

    logic [63:0]       scratch_q, scratch_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              rvalid_q;
    logic [63:0]       wmask;
    logic [12:0]       word;
    logic              wr_scratch, wr_err, wr_ctrl;
    logic              unused_addr_lsb;

    t_dfh                       dfh;
    t_effmon_state              eff_state;
    logic                       eff_overflow;
    logic [NUM_CH:0][CNT_W-1:0] eff_cnt;
    logic [63:0]                emif_status, emif_cap;

    assign word            = word_addr(csr.csr_addr);
    assign unused_addr_lsb = ^csr.csr_addr[2:0];

    assign wr_scratch = csr.csr_wr && (word == word_addr(ADDR_SCRATCH));
    assign wr_err     = csr.csr_wr && (word == word_addr(ADDR_ERR_STAT));
    assign wr_ctrl    = csr.csr_wr && (word == word_addr(ADDR_EFF_CTRL));

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{csr.csr_wstrb[gi]}};
        end
    endgenerate

    always_comb begin
        scratch_d = scratch_q;
        if (wr_scratch) scratch_d = (scratch_q & ~wmask) | (csr.csr_wdata & wmask);
    end

    // a new error in the same cycle as its W1C survives the clear
    always_comb begin
        err_d = err_q;
        if (wr_err) err_d = err_d & ~csr.csr_wdata[NUM_CH-1:0];
        err_d = err_d | ch_err;
    end

    mem_ss_effmon #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_effmon (
        .clk        (clk),
        .rst        (rst),
        .start_i    (wr_ctrl && csr.csr_wdata[0]),
        .stop_i     (wr_ctrl && csr.csr_wdata[1]),
        .clear_i    (wr_ctrl && csr.csr_wdata[2]),
        .beat_i     (ch_beat),
        .state_o    (eff_state),
        .overflow_o (eff_overflow),
        .cnt_o      (eff_cnt)
    );

    always_comb begin
        dfh                = '0;
        dfh.feat_type      = DFH_FEAT_TYPE;
        dfh.min_ver        = MIN_VER[3:0];
        dfh.eol            = EOL;
        dfh.nxt_dfh_offset = NXT_DFH_OFFSET;
        dfh.maj_ver        = MAJ_VER[3:0];
        dfh.feat_id        = FEAT_ID;

        emif_status                = '0;
        emif_status[NUM_CH-1:0]    = cal_success;
        emif_status[16 +: NUM_CH]  = cal_fail;
        emif_cap                   = '0;
        emif_cap[NUM_CH-1:0]       = '1;
    end

    // read mux sees pre-write register values, so same-cycle write/read returns old data
    always_comb begin
        rdata_d = '0;
        if (word == word_addr(ADDR_DFH))        rdata_d = dfh;
        if (word == word_addr(ADDR_EMIF_STAT))  rdata_d = emif_status;
        if (word == word_addr(ADDR_EMIF_CAP))   rdata_d = emif_cap;
        if (word == word_addr(ADDR_MEMSS_VER))  rdata_d = {8'h0, MEM_TYPE, 14'h0, IF_TYPE,
                                                           MAJ_VER, MIN_VER, 8'h0};
        if (word == word_addr(ADDR_FEAT_LIST2)) rdata_d = {60'h0, 4'(NUM_CH + HPS_PRESENT)};
        if (word == word_addr(ADDR_IF_ATTR))    rdata_d = '0;
        if (word == word_addr(ADDR_SCRATCH))    rdata_d = scratch_q;
        if (word == word_addr(ADDR_ERR_STAT))   rdata_d = 64'(err_q);
        if (word == word_addr(ADDR_EFF_CTRL))   rdata_d = {55'h0, eff_overflow, 6'h0, eff_state};
        if (word == word_addr(ADDR_EFF_TOTAL))  rdata_d = 64'(eff_cnt[0]);
        for (int c = 0; c < NUM_CH; c++) begin
            if (word == word_addr(ADDR_CH_ATTR0) + 13'(c))
                rdata_d = CH_ATTR_FIXED | 64'(RDY_LATENCY);
            if (word == word_addr(ADDR_EFF_BUSY0) + 13'(c))
                rdata_d = 64'(eff_cnt[c+1]);
        end
        if (!csr.csr_rd) rdata_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch_q <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= csr.csr_rd;
        end
    end

    assign csr.csr_rdata   = rdata_q;
    assign csr.csr_rvalid  = rvalid_q;
    assign effmon_running  = (eff_state == EFF_RUN);

endmodule

// File: tb/tb_mem_ss_csr_regs.sv
// Directed + randomized bench for mem_ss_csr_regs (2 channels + HPS, 16-bit counters)
// against a cycle-level behavioural model of the register map and monitor.
module tb_mem_ss_csr_regs;

    localparam int          NUM_CH = 2;
    localparam int          CNT_W  = 16;
    localparam longint      MAXV   = 65535;
    localparam logic [63:0] EXP_DFH     = 64'h3000_0100_0000_1009;
    localparam logic [63:0] EXP_VER     = 64'h0001_0000_0001_0000;
    localparam logic [63:0] EXP_CH_ATTR = 64'h0000_0000_0910_0003;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_CH-1:0] cal_success, cal_fail, ch_beat, ch_err;
    logic effmon_running;

    mem_ss_csr_regs_if bus();

    mem_ss_csr_regs #(
        .NUM_CH      (NUM_CH),
        .HPS_PRESENT (1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .csr            (bus),
        .cal_success    (cal_success),
        .cal_fail       (cal_fail),
        .ch_beat        (ch_beat),
        .ch_err         (ch_err),
        .effmon_running (effmon_running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [63:0] m_scratch;
    logic [1:0]  m_err;
    int          m_state;      // 0 idle, 1 run, 2 frozen
    longint      m_total;
    longint      m_busy [NUM_CH];
    bit          m_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scratch = '0;
        m_err     = '0;
        m_state   = 0;
        m_total   = 0;
        m_ovf     = 1'b0;
        for (int c = 0; c < NUM_CH; c++) m_busy[c] = 0;
    endtask

    function automatic logic [63:0] model_read(input logic [15:0] addr);
        logic [15:0] a;
        a = addr & 16'hFFF8;
        case (a)
            16'h0000: return EXP_DFH;
            16'h0008: return (64'(cal_fail) << 16) | 64'(cal_success);
            16'h0010: return 64'h3;
            16'h0860: return EXP_VER;
            16'h0868: return 64'h3;
            16'h0880: return m_scratch;
            16'h08B0: return 64'(m_err);
            16'h0900, 16'h0908: return EXP_CH_ATTR;
            16'h1000: return (64'(m_ovf) << 8) | 64'(m_state);
            16'h1008: return 64'(m_total);
            16'h1010: return 64'(m_busy[0]);
            16'h1018: return 64'(m_busy[1]);
            default:  return 64'h0;
        endcase
    endfunction

    task automatic model_update(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                                input logic [7:0] ws, input logic [1:0] beat, input logic [1:0] err);
        logic [15:0] a;
        bit start, stop, clr;
        a     = addr & 16'hFFF8;
        start = wr && a == 16'h1000 && wd[0];
        stop  = wr && a == 16'h1000 && wd[1];
        clr   = wr && a == 16'h1000 && wd[2];
        if (!clr && m_state == 1) begin
            if (m_total < MAXV) begin
                m_total++;
                if (m_total == MAXV) m_ovf = 1'b1;
            end
            for (int c = 0; c < NUM_CH; c++)
                if (beat[c] && m_busy[c] < MAXV) begin
                    m_busy[c]++;
                    if (m_busy[c] == MAXV) m_ovf = 1'b1;
                end
        end
        if (clr) begin
            m_total = 0;
            for (int c = 0; c < NUM_CH; c++) m_busy[c] = 0;
            m_ovf = 1'b0;
        end
        if (stop) begin
            if (m_state == 1) m_state = 2;
        end else if (start) begin
            m_state = 1;
        end
        if (wr && a == 16'h0880)
            for (int b = 0; b < 8; b++)
                if (ws[b]) m_scratch[b*8 +: 8] = wd[b*8 +: 8];
        if (wr && a == 16'h08B0) m_err = m_err & ~wd[1:0];
        m_err = m_err | err;
    endtask

    // one clock: drive, update model at the edge, check 1 ns later
    task automatic step(input bit wr, input bit rd, input logic [15:0] addr, input logic [63:0] wd,
                        input logic [7:0] ws, input logic [1:0] beat, input logic [1:0] err);
        logic [63:0] exp_rd;
        bus.csr_wr    = wr;
        bus.csr_rd    = rd;
        bus.csr_addr  = addr;
        bus.csr_wdata = wd;
        bus.csr_wstrb = ws;
        ch_beat       = beat;
        ch_err        = err;
        exp_rd        = model_read(addr);
        @(posedge clk);
        model_update(wr, addr, wd, ws, beat, err);
        #1;
        if (rd) begin
            check($sformatf("rvalid@%h", addr), 64'(bus.csr_rvalid), 64'd1);
            check($sformatf("rdata@%h", addr), bus.csr_rdata, exp_rd);
            $display("rd addr=%h data=%h", addr, bus.csr_rdata);
        end else begin
            check("rvalid_idle", 64'(bus.csr_rvalid), 64'd0);
        end
        check("running", 64'(effmon_running), 64'(m_state == 1));
        bus.csr_wr = 1'b0;
        bus.csr_rd = 1'b0;
        ch_beat    = '0;
        ch_err     = '0;
    endtask

    task automatic rd(input logic [15:0] addr);
        step(1'b0, 1'b1, addr, 64'h0, 8'h0, 2'b00, 2'b00);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [63:0] wd, input logic [7:0] ws);
        step(1'b1, 1'b0, addr, wd, ws, 2'b00, 2'b00);
        $display("wr addr=%h data=%h strb=%h", addr, wd, ws);
    endtask

    task automatic read_monitor();
        rd(16'h1000);
        rd(16'h1008);
        rd(16'h1010);
        rd(16'h1018);
    endtask

    initial begin
        rst           = 1'b1;
        bus.csr_wr    = 1'b0;
        bus.csr_rd    = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_wdata = '0;
        bus.csr_wstrb = '0;
        cal_success   = '0;
        cal_fail      = '0;
        ch_beat       = '0;
        ch_err        = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", bus.csr_rdata, 64'h0);
        check("rst_rvalid", 64'(bus.csr_rvalid), 64'h0);
        check("rst_running", 64'(effmon_running), 64'h0);
        rst = 1'b0;

        // identity and status registers
        rd(16'h0000);
        rd(16'h0860);
        rd(16'h0868);
        rd(16'h0870);
        rd(16'h0010);
        rd(16'h0900);
        rd(16'h090C);
        rd(16'h0910);
        rd(16'h2000);
        for (int i = 0; i < 4; i++) begin
            cal_success = 2'($urandom);
            cal_fail    = 2'($urandom);
            rd(16'h0008);
        end

        // scratch byte enables, RO write ignored, same-cycle write/read
        wr(16'h0880, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        rd(16'h0880);
        wr(16'h0860, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        rd(16'h0860);
        for (int i = 0; i < 6; i++) begin
            wr(16'h0880, {$urandom, $urandom}, 8'($urandom));
            rd(16'h0884);
        end
        step(1'b1, 1'b1, 16'h0880, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 2'b00);
        rd(16'h0880);

        // sticky errors, set beats clear
        step(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 2'b00, 2'b10);
        rd(16'h08B0);
        step(1'b1, 1'b0, 16'h08B0, 64'h2, 8'hFF, 2'b00, 2'b10);
        rd(16'h08B0);
        wr(16'h08B0, 64'h2, 8'hFF);
        rd(16'h08B0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 16'h08B0, 64'($urandom_range(0, 3)), 8'hFF, 2'b00, 2'($urandom));
            rd(16'h08B0);
        end

        // monitor: 20 RUN cycles, 10 beats on channel 0
        wr(16'h1000, 64'h1, 8'hFF);
        for (int i = 0; i < 19; i++)
            step(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, (i % 2 == 0) ? 2'b01 : 2'b00, 2'b00);
        step(1'b1, 1'b0, 16'h1000, 64'h2, 8'hFF, 2'b00, 2'b00);
        read_monitor();
        check("total20", 64'(m_total), 64'd20);

        // restart resumes, then assorted control combinations with random beats
        wr(16'h1000, 64'h1, 8'hFF);
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 2'($urandom), 2'b00);
        wr(16'h1000, 64'h2, 8'hFF);
        read_monitor();
        wr(16'h1000, 64'h5, 8'hFF);
        read_monitor();
        wr(16'h1000, 64'h3, 8'hFF);
        read_monitor();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 16'h1000, 64'($urandom_range(0, 7)), 8'hFF, 2'($urandom), 2'b00);
            for (int j = 0; j < 3; j++)
                step(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 2'($urandom), 2'b00);
            read_monitor();
        end

        // saturation and overflow
        wr(16'h1000, 64'h5, 8'hFF);
        for (int i = 0; i < 70000; i++)
            step(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 2'($urandom), 2'b00);
        read_monitor();
        check("total_sat", 64'(m_total), 64'hFFFF);
        wr(16'h1000, 64'h4, 8'hFF);
        rd(16'h1008);
        rd(16'h1010);
        rd(16'h1018);
        rd(16'h1000);

        // asynchronous reset while running with a read in flight
        bus.csr_rd   = 1'b1;
        bus.csr_addr = 16'h1008;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_rvalid", 64'(bus.csr_rvalid), 64'h0);
        check("arst_rdata", bus.csr_rdata, 64'h0);
        check("arst_running", 64'(effmon_running), 64'h0);
        @(posedge clk);
        #1;
        check("arst_rvalid_edge", 64'(bus.csr_rvalid), 64'h0);
        bus.csr_rd = 1'b0;
        rst = 1'b0;
        read_monitor();
        rd(16'h0880);
        rd(16'h08B0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ss_csr_regs.md
Name: mem_ss_csr_regs

Overview:
Parametrised CSR block for the memory subsystem, covering 1..8 channels (plus an optional HPS channel). It provides the EMIF DFH feature header, EMIF status and capability registers, the MEM_SS version, feature-list and channel-attribute registers, and a byte-enabled scratch register. It also has sticky per-channel error latches and a new per-channel efficiency monitor with a start/stop/clear state machine. It sits behind the FME/port CSR decoder on the host CSR clock.

Parameters:
NUM_CH, 2, number of fabric memory channels (1..8).
HPS_PRESENT, 0, 1 adds an HPS channel to the reported channel count.
CNT_W, 32, efficiency counter width (16..64); counters are zero-extended to 64 bits on read.
FEAT_ID, 12'h9, DFH feature id.
NXT_DFH_OFFSET, 24'h0, DFH next-header offset.
EOL, 1'b1, DFH end-of-list bit.
MAJ_VER / MIN_VER, 16'h1 / 8'h0, MEM_SS version.
MEM_TYPE / IF_TYPE, 8'h1 / 2'h0, DDR4 / AXI4.
RDY_LATENCY, 4'h3, channel ready latency.

Ports:
clk  in  1  CSR clock.
rst  in  1  asynchronous reset, active-high.
csr_wr  in  1  write strobe, single cycle.
csr_rd  in  1  read strobe, single cycle.
csr_addr  in  16  byte address; bits [2:0] are ignored (64-bit words).
csr_wdata  in  64  write data.
csr_wstrb  in  8  byte enables; honoured by the scratch register only.
csr_rdata  out  64  read data.
csr_rvalid  out  1  read data valid.
cal_success  in  NUM_CH  per-channel calibration pass level, already synchronous to clk.
cal_fail  in  NUM_CH  per-channel calibration fail level.
ch_beat  in  NUM_CH  per-channel pulse: a rd/wr beat was accepted this cycle.
ch_err  in  NUM_CH  per-channel error pulse (ECC/timeout).
effmon_running  out  1  high while the efficiency monitor is in RUN.

Behaviour:
- Reset values: csr_rdata=0, csr_rvalid=0, scratch=0, sticky errors=0, all counters=0, monitor state=IDLE, overflow flag=0, effmon_running=0.
- Read latency is exactly 1 cycle: csr_rd in cycle N gives csr_rvalid=1 with data in N+1, and csr_rvalid=0 otherwise.
- Unmapped reads return 0. Writes to RO or unmapped addresses are ignored.
- If csr_wr and csr_rd hit the same address in the same cycle, the read returns the pre-write value.
- Register map (byte offsets):
  - 0x000 DFH: {feat_type=4'h3, 8'h0, MIN_VER[3:0], 7'h0, EOL, NXT_DFH_OFFSET, MAJ_VER[3:0], FEAT_ID}.
  - 0x008 EMIF_STATUS (RO): [c]=cal_success[c], [16+c]=cal_fail[c].
  - 0x010 EMIF_CAPABILITY (RO): [c]=1 for c<NUM_CH.
  - 0x860 (RO): [31:0]={MAJ_VER,MIN_VER,8'h0}, [63:32]={8'h0,MEM_TYPE,14'h0,IF_TYPE}.
  - 0x868 FEAT_LIST_2 (RO): [3:0]=NUM_CH+HPS_PRESENT.
  - 0x870 IF_ATTR (RO): 0.
  - 0x880 SCRATCH (RW): byte-enabled.
  - 0x8B0 ERR_STATUS (W1C): [c]=sticky ch_err. If a set and a clear coincide, the set wins.
  - 0x900+8c CH_ATTR (RO): {..., bit27=1 auto-precharge, [26:24]=1 usr pools, [23:20]=1 wr copies, [3:0]=RDY_LATENCY}.
  - 0x1000 EFFMON_CTRL: write bit0=start, bit1=stop, bit2=clear. Read returns [1:0]=state, [8]=overflow.
  - 0x1008 EFFMON_TOTAL: cycles spent in RUN.
  - 0x1010+8c EFFMON_BUSY[c]: ch_beat count while in RUN.
- Monitor FSM states: IDLE(0), RUN(1), FROZEN(2).
  - start: IDLE→RUN or FROZEN→RUN. Counts resume without clearing.
  - stop: RUN→FROZEN.
  - clear: zeroes all counters and the overflow flag in all states; the state is unchanged.
  - start+clear together: clear first, then enter RUN; the next cycle counts from 0.
  - start+stop together: stop wins.
  - Counting is active only in RUN: TOTAL+=1 each cycle, BUSY[c]+=ch_beat[c]. The cycle of the start write itself is not counted.
  - Counters saturate at all-ones; reaching saturation sets overflow (sticky until clear).
  - A clear coinciding with an increment: clear wins.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending read produces no csr_rvalid.

Decomposition:
- Package mem_ss_csr_pkg holds:
  - the t_dfh struct;
  - all address offsets;
  - the version/attribute localparams;
  - the t_effmon_state enum.
- Sub-module mem_ss_effmon: the FSM plus NUM_CH+1 saturating CNT_W counters.
- mem_ss_csr_regs handles decode, registers and the read mux.

Test Plan:
- Reset, then read 0x000/0x860/0x868 with NUM_CH=2, HPS_PRESENT=1 → DFH feat_id 9, eol 1; 0x860=0x0001_0000_0001_0000 (low word 0x0001_0000, high word 0x0001_0000); 0x868=3.
- Write 0x880 with data 0xFFFF_FFFF_FFFF_FFFF, wstrb 0x0F → read returns 0x0000_0000_FFFF_FFFF; read of unmapped 0x2000 returns 0 with rvalid one cycle after rd.
- Pulse ch_err[1]; write 0x8B0=0x2 in the same cycle as a second ch_err[1] pulse → bit1 stays 1; a later W1C clears it to 0.
- Start monitor, drive ch_beat=2'b01 for 10 of 20 cycles, stop → TOTAL=20, BUSY0=10, BUSY1=0, state=FROZEN; a restart continues from those values.
- CNT_W=16: run 70000 cycles → TOTAL=0xFFFF and overflow=1; write clear → all counters 0, overflow 0, state still RUN.
- Assert rst while in RUN with a read in flight → outputs 0, no rvalid, state IDLE.
